// File: rtl/core_mem_arbiter.sv
// Core memory arbiter: merges instruction and data ports onto one
// shared memory port and routes in-order responses back to their source.
module core_mem_arbiter #(
  parameter int MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        spurious_rsp_o
);

  localparam logic [2:0] MaxCnt  = 3'(MaxOutstanding);
  localparam logic [1:0] LastPtr = 2'(MaxOutstanding - 1);

  // Outstanding FIFO holds one source bit per entry: 0=instr, 1=data
  logic [3:0] src_q;
  logic [1:0] wptr_q;
  logic [1:0] rptr_q;
  logic [2:0] count_q;
  logic       last_q;
  logic       lock_vld_q;
  logic       lock_src_q;

  logic any_req;
  logic lock_hold;
  logic sel_data;
  logic fwd_ok;
  logic push;
  logic pop;
  logic head_src;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LastPtr) ? 2'd0 : p + 2'd1;
  endfunction

  // Source selection: honour the lock, else alternate on conflict
  always_comb begin
    any_req   = instr_req_i | data_req_i;
    lock_hold = lock_vld_q &
                (lock_src_q ? data_req_i : instr_req_i);
    sel_data  = 1'b0;
    if (lock_hold) begin
      sel_data = lock_src_q;
    end else if (instr_req_i && data_req_i) begin
      sel_data = ~last_q;
    end else begin
      sel_data = data_req_i;
    end
  end

  // A full FIFO still accepts when a response frees a slot this cycle
  assign fwd_ok = (count_q < MaxCnt) |
                  ((count_q == MaxCnt) & mem_rvalid_i);

  assign mem_req_o = fwd_ok & any_req;
  assign push      = mem_req_o & mem_gnt_i;
  assign pop       = mem_rvalid_i & (count_q != 3'd0);
  assign head_src  = src_q[rptr_q];

  // Request-side mux toward memory
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (any_req && sel_data) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end else if (any_req) begin
      mem_be_o    = 4'hF;
      mem_addr_o  = instr_addr_i;
    end
  end

  assign instr_gnt_o = push & ~sel_data;
  assign data_gnt_o  = push & sel_data;

  assign instr_rvalid_o = pop & ~head_src;
  assign data_rvalid_o  = pop & head_src;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = instr_rvalid_o & mem_err_i;
  assign data_err_o     = data_rvalid_o & mem_err_i;

  assign spurious_rsp_o = mem_rvalid_i & (count_q == 3'd0);

  // FIFO, count, fairness and lock state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      src_q      <= 4'h0;
      wptr_q     <= 2'd0;
      rptr_q     <= 2'd0;
      count_q    <= 3'd0;
      last_q     <= 1'b1;
      lock_vld_q <= 1'b0;
      lock_src_q <= 1'b0;
    end else begin
      if (push) begin
        src_q[wptr_q] <= sel_data;
        wptr_q        <= ptr_inc(wptr_q);
        last_q        <= sel_data;
      end
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      count_q <= count_q + {2'b0, push} - {2'b0, pop};
      if (push) begin
        lock_vld_q <= 1'b0;
      end else if (mem_req_o) begin
        lock_vld_q <= 1'b1;
        lock_src_q <= sel_data;
      end else if (!lock_hold) begin
        lock_vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed testbench for core_mem_arbiter
// (MaxOutstanding = 2).
module tb_core_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
  logic        spurious_rsp_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  core_mem_arbiter #(.MaxOutstanding(2)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .data_err_o     (data_err_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .mem_err_i      (mem_err_i),
    .spurious_rsp_o (spurious_rsp_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_ni       = 1'b0;
    instr_req_i  = 1'b0;
    instr_addr_i = 32'h0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = 4'h0;
    data_addr_i  = 32'h0;
    data_wdata_i = 32'h0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    mem_err_i    = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    settle();
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_igqnt", 32'(instr_gnt_o), 32'd0);
    chk("rst_dgnt", 32'(data_gnt_o), 32'd0);
    chk("rst_spur", 32'(spurious_rsp_o), 32'd0);
    chk("rst_rv", 32'({instr_rvalid_o, data_rvalid_o}), 32'd0);

    // Alternating grants on persistent conflict
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_0100;
    data_req_i   = 1'b1;
    data_be_i    = 4'hF;
    data_addr_i  = 32'h0000_0200;
    mem_gnt_i    = 1'b1;
    settle();
    chk("rr1_igrant", 32'(instr_gnt_o), 32'd1);
    chk("rr1_dgrant", 32'(data_gnt_o), 32'd0);
    chk("rr1_addr", mem_addr_o, 32'h0000_0100);
    step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1111_1111;
    settle();
    chk("rr2_dgrant", 32'(data_gnt_o), 32'd1);
    chk("rr2_addr", mem_addr_o, 32'h0000_0200);
    chk("rr2_irv", 32'(instr_rvalid_o), 32'd1);
    step();
    settle();
    chk("rr3_igrant", 32'(instr_gnt_o), 32'd1);
    chk("rr3_drv", 32'(data_rvalid_o), 32'd1);
    step();
    settle();
    chk("rr4_dgrant", 32'(data_gnt_o), 32'd1);
    chk("rr4_irv", 32'(instr_rvalid_o), 32'd1);
    step();
    instr_req_i = 1'b0;
    data_req_i  = 1'b0;
    settle();
    chk("rr_drain_drv", 32'(data_rvalid_o), 32'd1);
    chk("rr_drain_spur", 32'(spurious_rsp_o), 32'd0);
    step();
    mem_rvalid_i = 1'b0;

    // Outstanding limit with three data reads
    data_req_i  = 1'b1;
    data_we_i   = 1'b0;
    data_addr_i = 32'h0000_0300;
    settle();
    chk("lim1_dgnt", 32'(data_gnt_o), 32'd1);
    step();
    settle();
    chk("lim2_dgnt", 32'(data_gnt_o), 32'd1);
    step();
    settle();
    chk("lim3_req", 32'(mem_req_o), 32'd0);
    chk("lim3_dgnt", 32'(data_gnt_o), 32'd0);
    step();
    settle();
    chk("lim4_req", 32'(mem_req_o), 32'd0);
    mem_rvalid_i = 1'b1;
    settle();
    chk("lim5_req", 32'(mem_req_o), 32'd1);
    chk("lim5_dgnt", 32'(data_gnt_o), 32'd1);
    chk("lim5_drv", 32'(data_rvalid_o), 32'd1);
    step();
    mem_rvalid_i = 1'b0;
    settle();
    chk("lim6_full", 32'(mem_req_o), 32'd0);
    data_req_i   = 1'b0;
    mem_rvalid_i = 1'b1;
    settle();
    chk("lim7_drv", 32'(data_rvalid_o), 32'd1);
    step();
    settle();
    chk("lim8_drv", 32'(data_rvalid_o), 32'd1);
    step();
    mem_rvalid_i = 1'b0;

    // In-order response routing
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_0400;
    settle();
    chk("ord_igrant", 32'(instr_gnt_o), 32'd1);
    step();
    instr_req_i = 1'b0;
    data_req_i  = 1'b1;
    settle();
    chk("ord_dgrant", 32'(data_gnt_o), 32'd1);
    step();
    data_req_i   = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEAD_BEEF;
    settle();
    chk("ord1_irv", 32'(instr_rvalid_o), 32'd1);
    chk("ord1_drv", 32'(data_rvalid_o), 32'd0);
    chk("ord1_rdata", instr_rdata_o, 32'hDEAD_BEEF);
    step();
    mem_rdata_i = 32'h1234_5678;
    settle();
    chk("ord2_drv", 32'(data_rvalid_o), 32'd1);
    chk("ord2_irv", 32'(instr_rvalid_o), 32'd0);
    chk("ord2_rdata", data_rdata_o, 32'h1234_5678);
    step();
    mem_rvalid_i = 1'b0;

    // Selection held stable while memory stalls
    mem_gnt_i    = 1'b0;
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_be_i    = 4'b0011;
    data_addr_i  = 32'h0000_1000;
    data_wdata_i = 32'hCAFE_0001;
    settle();
    chk("stl1_req", 32'(mem_req_o), 32'd1);
    chk("stl1_we", 32'(mem_we_o), 32'd1);
    chk("stl1_addr", mem_addr_o, 32'h0000_1000);
    chk("stl1_dgnt", 32'(data_gnt_o), 32'd0);
    step();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_0500;
    settle();
    chk("stl2_addr", mem_addr_o, 32'h0000_1000);
    chk("stl2_be", 32'(mem_be_o), 32'h3);
    chk("stl2_wdata", mem_wdata_o, 32'hCAFE_0001);
    chk("stl2_igqnt", 32'(instr_gnt_o), 32'd0);
    step();
    settle();
    chk("stl3_addr", mem_addr_o, 32'h0000_1000);
    chk("stl3_we", 32'(mem_we_o), 32'd1);
    step();
    mem_gnt_i = 1'b1;
    settle();
    chk("stl4_dgnt", 32'(data_gnt_o), 32'd1);
    chk("stl4_igqnt", 32'(instr_gnt_o), 32'd0);
    chk("stl4_addr", mem_addr_o, 32'h0000_1000);
    step();
    data_req_i = 1'b0;
    settle();
    chk("stl5_igqnt", 32'(instr_gnt_o), 32'd1);
    chk("stl5_be", 32'(mem_be_o), 32'hF);
    chk("stl5_wdata", mem_wdata_o, 32'h0);
    chk("stl5_we", 32'(mem_we_o), 32'd0);
    step();
    instr_req_i = 1'b0;

    // Error response on data, then clean instr response
    mem_rvalid_i = 1'b1;
    mem_err_i    = 1'b1;
    settle();
    chk("err1_drv", 32'(data_rvalid_o), 32'd1);
    chk("err1_derr", 32'(data_err_o), 32'd1);
    chk("err1_ierr", 32'(instr_err_o), 32'd0);
    step();
    mem_err_i = 1'b0;
    settle();
    chk("err2_irv", 32'(instr_rvalid_o), 32'd1);
    chk("err2_errs", 32'({instr_err_o, data_err_o}), 32'd0);
    step();

    // Spurious responses: empty FIFO, then after reset
    settle();
    chk("spur1", 32'(spurious_rsp_o), 32'd1);
    chk("spur1_rv", 32'({instr_rvalid_o, data_rvalid_o}), 32'd0);
    step();
    mem_rvalid_i = 1'b0;
    settle();
    chk("spur1_off", 32'(spurious_rsp_o), 32'd0);
    instr_req_i = 1'b1;
    settle();
    chk("spur2_igqnt", 32'(instr_gnt_o), 32'd1);
    step();
    instr_req_i = 1'b0;
    rst_ni      = 1'b0;
    step();
    rst_ni       = 1'b1;
    mem_rvalid_i = 1'b1;
    settle();
    chk("spur2", 32'(spurious_rsp_o), 32'd1);
    chk("spur2_irv", 32'(instr_rvalid_o), 32'd0);
    step();
    mem_rvalid_i = 1'b0;
    settle();
    chk("spur2_off", 32'(spurious_rsp_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 The block SHALL have parameter MaxOutstanding, default 2, meaning the maximum number of granted-but-unanswered memory transactions (legal range 1..4).
REQ-002 The block SHALL have one clock and a synchronous, active-low reset; it SHALL have these ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_ni  in  1  synchronous active-low reset.
- instr_req_i  in  1  core instruction fetch request.
- instr_addr_i  in  32  fetch address.
- instr_gnt_o  out  1  fetch request accepted.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  32  fetch response data.
- instr_err_o  out  1  fetch response error.
- data_req_i  in  1  core data request.
- data_we_i  in  1  write enable.
- data_be_i  in  4  byte enables.
- data_addr_i  in  32  data address.
- data_wdata_i  in  32  write data.
- data_gnt_o  out  1  data request accepted.
- data_rvalid_o  out  1  data response valid.
- data_rdata_o  out  32  data response data.
- data_err_o  out  1  data response error.
- mem_req_o  out  1  shared-port request.
- mem_we_o  out  1  shared-port write enable.
- mem_be_o  out  4  shared-port byte enables.
- mem_addr_o  out  32  shared-port address.
- mem_wdata_o  out  32  shared-port write data.
- mem_gnt_i  in  1  shared-port grant.
- mem_rvalid_i  in  1  shared-port response valid (in order).
- mem_rdata_i  in  32  shared-port response data.
- mem_err_i  in  1  shared-port response error.
- spurious_rsp_o  out  1  one-cycle pulse: mem_rvalid_i arrived with no outstanding transaction.

Function
REQ-003 Protocol on all ports: req held until gnt; transaction accepted in the cycle req&gnt; exactly one rvalid per accepted transaction, in acceptance order, at least one cycle after acceptance.
REQ-004 Outstanding FIFO: depth MaxOutstanding, one source-ID bit per entry (0=instr, 1=data), plus count register 0..MaxOutstanding.
REQ-005 Push SHALL occur on mem_req_o&mem_gnt_i with the selected source ID; pop SHALL occur on mem_rvalid_i when count>0.
REQ-006 Forwarding allowed when count<MaxOutstanding, or count==MaxOutstanding and mem_rvalid_i is high in the same cycle (pop and push same cycle, count unchanged).
REQ-007 When forwarding not allowed, mem_req_o SHALL be 0 and both gnt outputs 0.
REQ-008 Selection (combinational): only one requester -> that one; both -> the requester opposite to last_grant register; last_grant SHALL update to the accepted source on each push.
REQ-009 mem_req_o = forwarding allowed & (instr_req_i | data_req_i).
REQ-010 Selected data: mem_we/be/addr/wdata = data_we_i/data_be_i/data_addr_i/data_wdata_i; selected instr: mem_we_o=0, mem_be_o=4'hF, mem_addr_o=instr_addr_i, mem_wdata_o=0; no request: all these 0.
REQ-011 instr_gnt_o / data_gnt_o SHALL equal mem_gnt_i & mem_req_o & (selected source); the unselected requester's gnt SHALL be 0.
REQ-012 Selection SHALL be stable while mem_req_o is high and mem_gnt_i low (selection locked in lock register until acceptance or until the locked requester drops req).
REQ-013 Response routing: on mem_rvalid_i with count>0, rvalid/rdata/err SHALL go to the FIFO-head source in the same cycle; the other side's rvalid 0; rdata outputs SHALL equal mem_rdata_i regardless of rvalid, err outputs gated by rvalid.
REQ-014 mem_rvalid_i with count==0: no rvalid to either side, spurious_rsp_o=1 for that cycle, count stays 0.
REQ-015 FIFO read/write pointers SHALL wrap modulo MaxOutstanding.

Reset
REQ-016 With rst_ni low at a clock edge: count=0, pointers=0, last_grant=data (so instr wins first conflict), lock cleared; outputs driven from this state (gnt/rvalid/mem_req/spurious 0 when inputs idle).
REQ-017 Reset mid-transaction SHALL discard all outstanding entries; later mem_rvalid_i SHALL assert spurious_rsp_o.

Verification
REQ-018 Both req high from reset, mem_gnt_i=1 -> grants instr, data, instr, data on consecutive cycles (MaxOutstanding large enough, rvalid each cycle).
REQ-019 Three data reads accepted, no rvalid, MaxOutstanding=2 -> third held, mem_req_o=0 until first mem_rvalid_i; same-cycle rvalid+accept keeps count=2.
REQ-020 Instr then data accepted; rvalid with rdata 0xDEADBEEF then 0x12345678 -> instr_rvalid_o with 0xDEADBEEF, then data_rvalid_o with 0x12345678.
REQ-021 Data write be=4'b0011 addr 0x1000 wdata 0xCAFE0001, mem_gnt_i low 3 cycles while instr_req_i rises -> mem_* stay on the data write until gnt.
REQ-022 mem_rvalid_i with count 0, and rvalid after mid-flight reset -> spurious_rsp_o pulse, no core rvalid.
REQ-023 mem_err_i=1 on data response -> data_err_o=1 one cycle, instr_err_o=0.
